// File: rtl/relobi_single_mgr_pkg.sv
// Shared types, sizing helpers and Hsiao SECDED helpers for the single-outstanding relOBI manager.
// Address and data share one codec, so AddrWidth must equal DataWidth.
package relobi_single_mgr_pkg;

    localparam int AddrWidth = 32;
    localparam int DataWidth = 32;
    localparam int IdWidth   = 2;

    // Smallest SECDED check width for dw data bits.
    function automatic int min_ecc(input int dw);
        int r;
        r = 16;
        for (int k = 15; k >= 2; k--) begin
            if ((1 << (k - 1)) >= dw + k) r = k;
        end
        return r;
    endfunction

    function automatic int enc_width(input int dw);
        return dw + min_ecc(dw);
    endfunction

    localparam int EccW = min_ecc(DataWidth);
    localparam int EncW = enc_width(DataWidth);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} relobi_mgr_state_e;

    typedef logic a_optional_t;
    typedef logic r_optional_t;

    typedef struct packed {
        logic [EncW-1:0]          addr;
        logic                     we;
        logic [DataWidth/8-1:0]   be;
        logic [EncW-1:0]          wdata;
        logic [IdWidth-1:0]       aid;
        a_optional_t              a_optional;
        logic [EccW-1:0]          other_ecc;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
        logic        rready;
    } obi_req_t;

    typedef struct packed {
        logic [EncW-1:0]    rdata;
        logic [IdWidth-1:0] rid;
        logic               err;
        r_optional_t        r_optional;
        logic [EccW-1:0]    other_ecc;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic                 ce;
        logic                 ue;
    } hsiao_dec_t;

    // Data columns are the weight-3 check vectors in ascending numeric order.
    function automatic logic [DataWidth-1:0][EccW-1:0] hsiao_cols();
        logic [DataWidth-1:0][EccW-1:0] cols;
        logic [EccW-1:0] c;
        int n;
        cols = '0;
        n = 0;
        for (int v = 0; v < (1 << EccW); v++) begin
            c = EccW'(v);
            if ($countones(c) == 3 && n < DataWidth) begin
                cols[n] = c;
                n++;
            end
        end
        return cols;
    endfunction

    localparam logic [DataWidth-1:0][EccW-1:0] HCOL = hsiao_cols();

    function automatic logic [EccW-1:0] hsiao_parity(input logic [DataWidth-1:0] d);
        logic [EccW-1:0] p;
        p = '0;
        for (int j = 0; j < DataWidth; j++) begin
            if (d[j]) p = p ^ HCOL[j];
        end
        return p;
    endfunction

    function automatic logic [EncW-1:0] hsiao_enc(input logic [DataWidth-1:0] d);
        return {hsiao_parity(d), d};
    endfunction

    function automatic hsiao_dec_t hsiao_dec(input logic [EncW-1:0] cw);
        hsiao_dec_t res;
        logic [EccW-1:0] s;
        logic [DataWidth-1:0] flip;
        s = hsiao_parity(cw[DataWidth-1:0]) ^ cw[EncW-1:DataWidth];
        for (int j = 0; j < DataWidth; j++) flip[j] = (s == HCOL[j]);
        res.data = cw[DataWidth-1:0];
        res.ce   = 1'b0;
        res.ue   = 1'b0;
        if (s != '0) begin
            if (^s) begin
                if ($countones(s) == 1) begin
                    res.ce = 1'b1;
                end else if (|flip) begin
                    res.data = res.data ^ flip;
                    res.ce   = 1'b1;
                end else begin
                    res.ue = 1'b1;
                end
            end else begin
                res.ue = 1'b1;
            end
        end
        return res;
    endfunction

    // Non-data fields are zero-extended into the data codec.
    function automatic logic [DataWidth-1:0] a_other_vec(input logic we,
            input logic [DataWidth/8-1:0] be, input logic [IdWidth-1:0] aid,
            input a_optional_t opt);
        return DataWidth'({we, be, aid, opt});
    endfunction

    function automatic logic [EccW-1:0] a_other_enc(input logic we,
            input logic [DataWidth/8-1:0] be, input logic [IdWidth-1:0] aid,
            input a_optional_t opt);
        return hsiao_parity(a_other_vec(we, be, aid, opt));
    endfunction

    function automatic logic [DataWidth-1:0] r_other_vec(input logic [IdWidth-1:0] rid,
            input logic err, input r_optional_t opt);
        return DataWidth'({rid, err, opt});
    endfunction

endpackage

// File: rtl/relobi_single_mgr_dec.sv
// Combinational R-channel decode: corrects rdata and the {rid, err, r_optional} group,
// and merges both decoders' correctable/uncorrectable flags.
module relobi_single_mgr_dec
    import relobi_single_mgr_pkg::*;
(
    input  obi_r_chan_t          r,
    output logic [DataWidth-1:0] rdata,
    output logic [IdWidth-1:0]   rid,
    output logic                 err,
    output logic [1:0]           fault
);

    hsiao_dec_t d_dec, o_dec;

    assign d_dec = hsiao_dec(r.rdata);
    assign o_dec = hsiao_dec({r.other_ecc, r_other_vec(r.rid, r.err, r.r_optional)});

    assign rdata = d_dec.data;
    assign rid   = o_dec.data[IdWidth+1:2];
    assign err   = o_dec.data[1];
    assign fault = {d_dec.ue | o_dec.ue, d_dec.ce | o_dec.ce};

    logic unused_opt;
    assign unused_opt = ^{o_dec.data[DataWidth-1:IdWidth+2], o_dec.data[0]};

endmodule

// File: rtl/relobi_single_mgr.sv
// Single-outstanding relOBI manager: one ECC-protected transaction per command.
// Define RELOBI_MGR_ID_CHECK_EN for a rolling AID counter and rid checking.
module relobi_single_mgr
    import relobi_single_mgr_pkg::*;
#(
    parameter bit                 UseRReady = 1'b1,
    parameter logic [IdWidth-1:0] FixedAid  = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [AddrWidth-1:0]   cmd_addr_i,
    input  logic                   cmd_we_i,
    input  logic [DataWidth/8-1:0] cmd_be_i,
    input  logic [DataWidth-1:0]   cmd_wdata_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [DataWidth-1:0]   res_rdata_o,
    output logic                   res_err_o,
    output obi_req_t               obi_req_o,
    input  obi_rsp_t               obi_rsp_i,
    output logic [1:0]             fault_o
);

    relobi_mgr_state_e    state;
    obi_a_chan_t          a_q;
    logic                 req_q, rready_q;
    logic [DataWidth-1:0] dec_rdata;
    logic [IdWidth-1:0]   dec_rid;
    logic                 dec_err;
    logic [1:0]           dec_fault;
    logic [IdWidth-1:0]   next_aid;
    logic                 id_err;
    logic                 capture, spurious;

    relobi_single_mgr_dec u_dec (
        .r     (obi_rsp_i.r),
        .rdata (dec_rdata),
        .rid   (dec_rid),
        .err   (dec_err),
        .fault (dec_fault)
    );

`ifdef RELOBI_MGR_ID_CHECK_EN
    logic [IdWidth-1:0] id_cnt;
    assign next_aid = id_cnt;
    assign id_err   = (dec_rid != a_q.aid);
`else
    logic unused_rid;
    assign next_aid   = FixedAid;
    assign id_err     = 1'b0;
    assign unused_rid = ^dec_rid;
`endif

    // A zero-latency subordinate may return rvalid alongside gnt while still in REQ.
    assign capture  = obi_rsp_i.rvalid &&
                      ((state == WAIT_R && obi_req_o.rready) || (state == REQ && obi_rsp_i.gnt));
    assign spurious = obi_rsp_i.rvalid && (state == IDLE || state == RESP);

    always_comb begin
        obi_req_o        = '0;
        obi_req_o.req    = req_q;
        obi_req_o.a      = a_q;
        obi_req_o.rready = UseRReady ? rready_q : 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            a_q         <= '0;
            req_q       <= 1'b0;
            rready_q    <= 1'b0;
            cmd_ready_o <= 1'b1;
            res_valid_o <= 1'b0;
            res_rdata_o <= '0;
            res_err_o   <= 1'b0;
            fault_o     <= '0;
`ifdef RELOBI_MGR_ID_CHECK_EN
            id_cnt      <= '0;
`endif
        end else begin
            fault_o <= '0;
            case (state)
                IDLE: if (cmd_valid_i) begin
                    a_q.addr       <= hsiao_enc(cmd_addr_i);
                    a_q.we         <= cmd_we_i;
                    a_q.be         <= cmd_be_i;
                    a_q.wdata      <= hsiao_enc(cmd_wdata_i);
                    a_q.aid        <= next_aid;
                    a_q.a_optional <= 1'b0;
                    a_q.other_ecc  <= a_other_enc(cmd_we_i, cmd_be_i, next_aid, 1'b0);
                    req_q          <= 1'b1;
                    cmd_ready_o    <= 1'b0;
                    state          <= REQ;
                end
                REQ: if (obi_rsp_i.gnt) begin
                    req_q <= 1'b0;
`ifdef RELOBI_MGR_ID_CHECK_EN
                    id_cnt <= id_cnt + 1'b1;
`endif
                    if (capture) begin
                        res_valid_o <= 1'b1;
                        state       <= RESP;
                    end else begin
                        rready_q <= 1'b1;
                        state    <= WAIT_R;
                    end
                end
                WAIT_R: if (capture) begin
                    rready_q    <= 1'b0;
                    res_valid_o <= 1'b1;
                    state       <= RESP;
                end
                RESP: if (res_ready_i) begin
                    res_valid_o <= 1'b0;
                    cmd_ready_o <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (capture) begin
                res_rdata_o <= a_q.we ? '0 : dec_rdata;
                res_err_o   <= dec_err | dec_fault[1] | id_err;
                fault_o     <= {dec_fault[1], dec_fault[0] | id_err};
            end
            if (spurious) fault_o[1] <= 1'b1;
        end
    end

endmodule
